// File: rtl/nv_tx_scheduler_if.sv
// Requester/serializer bus of the transmit scheduler.
// master: the scheduler itself; slave: requesters and serializer around it.
interface nv_tx_scheduler_if #(
  parameter int N_REQ = 3,
  parameter int DW    = 8,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    ack;
  logic [N_REQ-1:0]    done;
  logic [N_REQ-1:0]    err;
  logic                tx_start;
  logic [DW-1:0]       tx_data;
  logic [1:0]          tx_status;
  logic                busy;
  logic [IDW-1:0]      grant_id;

  modport master (
    input  req, req_data, tx_status,
    output ack, done, err, tx_start, tx_data, busy, grant_id
  );

  modport slave (
    output req, req_data, tx_status,
    input  ack, done, err, tx_start, tx_data, busy, grant_id
  );
endinterface

// File: rtl/nv_tx_scheduler.sv
// Round-robin scheduler sharing one transmit serializer among N_REQ requesters.
// Latches the winner's word, pulses tx_start, follows the serializer status to
// completion / error / timeout and reports per-requester done/err.
// Optional feature macro: NV_TX_RETRY_EN (retry a failed transfer up to
// MAX_RETRY extra times before reporting err).
module nv_tx_scheduler #(
  parameter int N_REQ     = 3,
  parameter int DW        = 8,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_RETRY = 2,
  parameter int IDW       = 2
) (
  input logic               clkp,
  input logic               reset,
  nv_tx_scheduler_if.master bus
);

  localparam int TW  = $clog2(TIMEOUT);
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  // Elaboration-time parameter sanity
  if (N_REQ < 2) begin : g_chk_nreq
    $error("nv_tx_scheduler: N_REQ must be >= 2");
  end
  if (TIMEOUT < 2) begin : g_chk_timeout
    $error("nv_tx_scheduler: TIMEOUT must be >= 2");
  end
  if ((1 << IDW) < N_REQ) begin : g_chk_idw
    $error("nv_tx_scheduler: IDW too small for N_REQ");
  end
  if (MAX_RETRY < 0 || RCW < 1) begin : g_chk_retry
    $error("nv_tx_scheduler: MAX_RETRY must be >= 0");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACCEPT,
    WAIT_DONE
`ifdef NV_TX_RETRY_EN
    , RETRY
`endif
  } state_t;

  state_t state, state_nxt;

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   winner;
  logic [DW-1:0]    win_data;
  logic             any_req;
  logic [TW-1:0]    timer;
  logic             timed_out;
  logic             launch;
  logic             relaunch;
  logic             complete;
  logic             fail;
  logic             fail_final;

  logic [N_REQ-1:0] ack_q, done_q, err_q;
  logic [N_REQ-1:0] ack_nxt, done_nxt, err_nxt;
  logic             start_q, start_nxt;
  logic [DW-1:0]    tx_data_q;
  logic [IDW-1:0]   grant_q;

`ifdef NV_TX_RETRY_EN
  logic [RCW-1:0]   retry_cnt;
  logic             retry_ok;
  assign retry_ok = (retry_cnt < RCW'(MAX_RETRY));
`endif

  // Round-robin pick: first set req bit scanning upward from rr_ptr+1, wrapping
  always_comb begin : arb
    int unsigned idx;
    winner   = rr_ptr;
    win_data = '0;
    any_req  = 1'b0;
    idx      = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % N_REQ;
      if (!any_req && bus.req[idx]) begin
        any_req  = 1'b1;
        winner   = IDW'(idx);
        win_data = bus.req_data[idx*DW +: DW];
      end
    end
  end

  // State register
  always_ff @(posedge clkp or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; status 10 outranks 11, which outranks the timeout
  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    relaunch   = 1'b0;
    complete   = 1'b0;
    fail       = 1'b0;
    fail_final = 1'b0;
    timed_out  = (timer == T_LAST);
    case (state)
      IDLE: begin
        if (any_req) begin
          launch    = 1'b1;
          state_nxt = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT, WAIT_DONE: begin
        if (bus.tx_status == 2'b10) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (bus.tx_status == 2'b11 || timed_out) begin
          fail = 1'b1;
`ifdef NV_TX_RETRY_EN
          if (retry_ok) begin
            state_nxt = RETRY;
          end else begin
            fail_final = 1'b1;
            state_nxt  = IDLE;
          end
`else
          fail_final = 1'b1;
          state_nxt  = IDLE;
`endif
        end else if (state == WAIT_ACCEPT && bus.tx_status == 2'b01) begin
          state_nxt = WAIT_DONE;
        end
      end
`ifdef NV_TX_RETRY_EN
      RETRY: begin
        relaunch  = 1'b1;
        state_nxt = WAIT_ACCEPT;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered pulses and the bus drive
  always_comb begin
    ack_nxt   = launch     ? (N_REQ'(1) << winner)  : '0;
    done_nxt  = complete   ? (N_REQ'(1) << grant_q) : '0;
    err_nxt   = fail_final ? (N_REQ'(1) << grant_q) : '0;
    start_nxt = launch | relaunch;

    bus.ack      = ack_q;
    bus.done     = done_q;
    bus.err      = err_q;
    bus.tx_start = start_q;
    bus.tx_data  = tx_data_q;
    bus.grant_id = grant_q;
    bus.busy     = (state != IDLE);
  end

  // Datapath: pulse registers, latched word/grant, attempt timer, rr pointer
  always_ff @(posedge clkp or negedge reset) begin
    if (!reset) begin
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      start_q   <= 1'b0;
      tx_data_q <= '0;
      grant_q   <= '0;
      timer     <= '0;
      rr_ptr    <= IDW'(N_REQ - 1);
`ifdef NV_TX_RETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      ack_q   <= ack_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      start_q <= start_nxt;
      if (launch) begin
        tx_data_q <= win_data;
        grant_q   <= winner;
      end
      if (launch || relaunch) begin
        timer <= '0;
      end else if ((state == WAIT_ACCEPT || state == WAIT_DONE) && timer != T_LAST) begin
        timer <= timer + TW'(1);
      end
      if (complete || fail_final) begin
        rr_ptr <= grant_q;
      end
`ifdef NV_TX_RETRY_EN
      if (launch) begin
        retry_cnt <= '0;
      end else if (fail && retry_ok) begin
        retry_cnt <= retry_cnt + RCW'(1);
      end
`endif
    end
  end

endmodule
